c_wait_fork3_sync: RTL and testbench

//  Clocked 3-way fork: the split counterpart of the 3-input wait-merge join. One upstream drive event
//  and its concatenated payload fan out as drive pulses on three downstream branches, each with its
//  own payload slice. Upstream gets one free pulse only after all three branches have returned free.

---
 rtl/c_wait_fork3_sync.sv | 229 ++++++++++++++++++++++
 tb/tb_c_wait_fork3_sync.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/c_wait_fork3_sync.sv
// Clocked 3-way fork: one upstream drive event fans out as simultaneous drive pulses on three
// branches, and upstream is freed only once every branch has returned its own free event.
module c_wait_fork3_sync #(
  parameter int DATA_WIDTH_O0 = 1,
  parameter int DATA_WIDTH_O1 = 3,
  parameter int DATA_WIDTH_O2 = 3,
  parameter int SYNC_STAGES   = 2,
  parameter int PULSE_W       = 2
) (
  input  logic                                                 clk,
  input  logic                                                 rstn,
  input  logic                                                 i_drive,
  input  logic [DATA_WIDTH_O0+DATA_WIDTH_O1+DATA_WIDTH_O2-1:0] i_data,
  output logic                                                 o_free,
  output logic                                                 o_drive0,
  output logic                                                 o_drive1,
  output logic                                                 o_drive2,
  output logic [DATA_WIDTH_O0-1:0]                             o_data0,
  output logic [DATA_WIDTH_O1-1:0]                             o_data1,
  output logic [DATA_WIDTH_O2-1:0]                             o_data2,
  input  logic                                                 i_free0,
  input  logic                                                 i_free1,
  input  logic                                                 i_free2,
  output logic                                                 o_busy,
  output logic                                                 o_err
);

  localparam int CW = $clog2(PULSE_W + 1);
  localparam int MW = $clog2(SYNC_STAGES + 2);
  localparam int B1 = DATA_WIDTH_O0;
  localparam int B2 = DATA_WIDTH_O0 + DATA_WIDTH_O1;
  localparam int DW = DATA_WIDTH_O0 + DATA_WIDTH_O1 + DATA_WIDTH_O2;

  localparam logic [CW-1:0] CNT_LOAD  = CW'(PULSE_W);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [MW-1:0] MASK_LOAD = MW'(SYNC_STAGES + 1);
  localparam logic [MW-1:0] MASK_ZERO = MW'(0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2,
    ST_FREE = 2'd3
  } state_t;

  logic [3:0]    w_raw;
  logic [3:0]    w_sync;
  logic [3:0]    w_ev;
  logic          w_armed;
  logic          w_drive_ev;
  logic [2:0]    w_free_ev;
  logic [3:0]    r_prev;
  logic [MW-1:0] r_mask;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [2:0]    r_done;
  logic [2:0]    w_done_nxt;
  logic          w_capture;
  logic          w_viol;

  logic                     r_err;
  logic                     r_drive;
  logic                     r_free;
  logic                     r_busy;
  logic [DATA_WIDTH_O0-1:0] r_data0;
  logic [DATA_WIDTH_O1-1:0] r_data1;
  logic [DATA_WIDTH_O2-1:0] r_data2;

  assign w_raw = {i_free2, i_free1, i_free0, i_drive};

  generate
    if (SYNC_STAGES > 0) begin : g_sync
      logic [3:0] r_sync [SYNC_STAGES];

      // Synchroniser chain shared by the drive and the three free inputs.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          for (int i = 0; i < SYNC_STAGES; i++) begin
            r_sync[i] <= 4'b0000;
          end
        end else begin
          r_sync[0] <= w_raw;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            r_sync[i] <= r_sync[i-1];
          end
        end
      end

      assign w_sync = r_sync[SYNC_STAGES-1];
    end else begin : g_nosync
      assign w_sync = w_raw;
    end
  endgenerate

  // Edge history plus a post-reset mask so a level held across reset is not seen as a rise.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_prev <= 4'b0000;
      r_mask <= MASK_LOAD;
    end else begin
      r_prev <= w_sync;
      if (r_mask != MASK_ZERO) begin
        r_mask <= r_mask - MW'(1);
      end else begin
        r_mask <= r_mask;
      end
    end
  end

  assign w_armed    = (r_mask == MASK_ZERO);
  assign w_ev       = w_sync & ~r_prev & {4{w_armed}};
  assign w_drive_ev = w_ev[0];
  assign w_free_ev  = w_ev[3:1];

  // Next-state, pulse counter and per-branch completion tracking.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = r_done;
    w_capture   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_drive_ev) begin
          w_state_nxt = ST_SEND;
          w_cnt_nxt   = CNT_LOAD;
          w_capture   = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SEND: begin
        // Frees that overtake the drive pulse are remembered, not dropped.
        w_done_nxt = r_done | w_free_ev;
        if (r_cnt == CNT_ONE) begin
          w_state_nxt = ST_WAIT;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      ST_WAIT: begin
        if ((r_done | w_free_ev) == 3'b111) begin
          w_state_nxt = ST_FREE;
          w_cnt_nxt   = CNT_LOAD;
          w_done_nxt  = 3'b000;
        end else begin
          w_done_nxt = r_done | w_free_ev;
        end
      end
      ST_FREE: begin
        if (r_cnt == CNT_ONE) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = CNT_LOAD;
        w_done_nxt  = 3'b000;
      end
    endcase
  end

  // Protocol violations only raise the sticky flag; the offending event is otherwise ignored.
  always_comb begin
    w_viol = 1'b0;
    if (w_drive_ev && (r_state != ST_IDLE)) begin
      w_viol = 1'b1;
    end else if ((w_free_ev & r_done) != 3'b000) begin
      w_viol = 1'b1;
    end else if ((w_free_ev != 3'b000) && ((r_state == ST_IDLE) || (r_state == ST_FREE))) begin
      w_viol = 1'b1;
    end else begin
      w_viol = 1'b0;
    end
  end

  // Control state and registered handshake outputs, all derived from the next state.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_cnt   <= {CW{1'b0}};
      r_done  <= 3'b000;
      r_err   <= 1'b0;
      r_drive <= 1'b0;
      r_free  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
      r_err   <= r_err | w_viol;
      r_drive <= (w_state_nxt == ST_SEND);
      r_free  <= (w_state_nxt == ST_FREE);
      r_busy  <= (w_state_nxt != ST_IDLE);
    end
  end

  // Branch payloads change only on an accepted drive event.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_data0 <= {DATA_WIDTH_O0{1'b0}};
      r_data1 <= {DATA_WIDTH_O1{1'b0}};
      r_data2 <= {DATA_WIDTH_O2{1'b0}};
    end else if (w_capture) begin
      r_data0 <= i_data[B1-1:0];
      r_data1 <= i_data[B2-1:B1];
      r_data2 <= i_data[DW-1:B2];
    end else begin
      r_data0 <= r_data0;
      r_data1 <= r_data1;
      r_data2 <= r_data2;
    end
  end

  assign o_drive0 = r_drive;
  assign o_drive1 = r_drive;
  assign o_drive2 = r_drive;
  assign o_free   = r_free;
  assign o_busy   = r_busy;
  assign o_err    = r_err;
  assign o_data0  = r_data0;
  assign o_data1  = r_data1;
  assign o_data2  = r_data2;

endmodule

// File: tb/tb_c_wait_fork3_sync.sv
// Bench for c_wait_fork3_sync: transaction-level timing model (latencies from input rises)
// compared cycle by cycle against the DUT outputs.
module tb_c_wait_fork3_sync;

  localparam int N  = 2;
  localparam int PW = 2;
  localparam int NEVER = 32'h7fff_ffff;

  logic       clk;
  logic       rstn;
  logic       i_drive;
  logic [6:0] i_data;
  logic       i_free0, i_free1, i_free2;
  logic       o_free, o_drive0, o_drive1, o_drive2;
  logic [0:0] o_data0;
  logic [2:0] o_data1, o_data2;
  logic       o_busy, o_err;

  int         checks;
  int         failures;
  int         cyc;
  int         err_at;
  logic       exp_err;
  logic [6:0] exp_data;

  c_wait_fork3_sync #(
    .DATA_WIDTH_O0(1), .DATA_WIDTH_O1(3), .DATA_WIDTH_O2(3),
    .SYNC_STAGES(N), .PULSE_W(PW)
  ) dut (
    .clk(clk), .rstn(rstn), .i_drive(i_drive), .i_data(i_data), .o_free(o_free),
    .o_drive0(o_drive0), .o_drive1(o_drive1), .o_drive2(o_drive2),
    .o_data0(o_data0), .o_data1(o_data1), .o_data2(o_data2),
    .i_free0(i_free0), .i_free1(i_free1), .i_free2(i_free2),
    .o_busy(o_busy), .o_err(o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // One transaction: drive rises now; free k rises dl_k cycles later. glitch/dup (>0) inject a
  // second drive rise or a repeated free0 rise at that offset. Expected timing comes from rises:
  // o_drive starts N+1 edges after the drive rise, o_free N+1 edges after the last free rise,
  // but never before the drive pulse has finished and one WAIT cycle has passed.
  task automatic run_txn(input string name, input logic [6:0] data,
                         input int dl0, input int dl1, input int dl2,
                         input int glitch, input int dup);
    int e, d_start, f_start, mx;
    logic e_drv, e_free, e_busy;
    e = cyc;
    i_data  = data;
    i_drive = 1'b1;
    mx = dl0;
    if (dl1 > mx) mx = dl1;
    if (dl2 > mx) mx = dl2;
    d_start = e + N + 1;
    f_start = e + mx + N + 1;
    if (f_start < e + N + PW + 2) f_start = e + N + PW + 2;
    if (glitch > 0) err_at = e + glitch + N + 1;
    if (dup > 0) err_at = e + dup + N + 1;
    for (int c = e + 1; c <= f_start + PW; c++) begin
      step();
      if (cyc >= err_at) exp_err = 1'b1;
      if (cyc >= d_start) exp_data = data;
      e_drv  = (cyc >= d_start) && (cyc < d_start + PW);
      e_free = (cyc >= f_start) && (cyc < f_start + PW);
      e_busy = (cyc >= d_start) && (cyc < f_start + PW);
      checks += 5;
      if ({o_drive2, o_drive1, o_drive0} !== {3{e_drv}}) begin
        failures++;
        $display("FAIL %s o_drive cyc=%0d got=%b%b%b exp=%b", name, c - e,
                 o_drive2, o_drive1, o_drive0, e_drv);
      end
      if (o_free !== e_free) begin
        failures++;
        $display("FAIL %s o_free cyc=%0d got=%b exp=%b", name, c - e, o_free, e_free);
      end
      if (o_busy !== e_busy) begin
        failures++;
        $display("FAIL %s o_busy cyc=%0d got=%b exp=%b", name, c - e, o_busy, e_busy);
      end
      if (o_err !== exp_err) begin
        failures++;
        $display("FAIL %s o_err cyc=%0d got=%b exp=%b", name, c - e, o_err, exp_err);
      end
      if ({o_data2, o_data1, o_data0} !== {exp_data[6:4], exp_data[3:1], exp_data[0]}) begin
        failures++;
        $display("FAIL %s o_data cyc=%0d got=%b_%b_%b exp=%b", name, c - e,
                 o_data2, o_data1, o_data0, exp_data);
      end
      if (cyc == e + dl0) i_free0 = 1'b1;
      if (cyc == e + dl1) i_free1 = 1'b1;
      if (cyc == e + dl2) i_free2 = 1'b1;
      if (glitch > 0 && cyc == e + glitch - 1) begin
        i_drive = 1'b0;
        i_data  = ~data;
      end
      if (glitch > 0 && cyc == e + glitch) i_drive = 1'b1;
      if (dup > 0 && cyc == e + dl0 + 2) i_free0 = 1'b0;
      if (dup > 0 && cyc == e + dup) i_free0 = 1'b1;
    end
    i_drive = 1'b0;
    i_free0 = 1'b0;
    i_free1 = 1'b0;
    i_free2 = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if ({o_drive2, o_drive1, o_drive0, o_free, o_busy, o_err, o_data2, o_data1, o_data0} !== 13'd0) begin
        failures++;
        $display("FAIL reset_outputs got=%b%b%b%b%b%b_%b_%b_%b exp=0", o_drive2, o_drive1, o_drive0,
                 o_free, o_busy, o_err, o_data2, o_data1, o_data0);
      end
    end
    rstn = 1'b1;
    for (int k = 0; k < N + 3; k++) step();
  endtask

  task automatic test_basic();
    run_txn("basic", 7'b101_011_1, 1, 3, 6, 0, 0);
    step();
  endtask

  task automatic test_same_cycle_free();
    run_txn("same_free", 7'b010_110_0, 4, 4, 4, 0, 0);
    step();
  endtask

  task automatic test_early_free();
    run_txn("early_free", 7'b111_001_1, 8, 1, 10, 0, 0);
    step();
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 10; t++) begin
      run_txn("b2b", 7'($urandom), $urandom_range(1, 10), $urandom_range(1, 10),
              $urandom_range(1, 10), 0, 0);
      step();
    end
  endtask

  task automatic test_drive_violation();
    run_txn("drive_viol", 7'b100_101_0, 12, 12, 12, 5, 0);
    step();
  endtask

  task automatic test_reset_midop();
    int e;
    e = cyc;
    i_data  = 7'b011_100_1;
    i_drive = 1'b1;
    for (int k = 1; k <= N + PW + 4; k++) begin
      step();
      if (cyc == e + 1) i_free0 = 1'b1;
      if (cyc == e + 2) i_free1 = 1'b1;
    end
    checks++;
    if ({o_busy, o_free, o_drive0} !== 3'b100) begin
      failures++;
      $display("FAIL midop_wait busy/free/drive got=%b%b%b exp=100", o_busy, o_free, o_drive0);
    end
    rstn = 1'b0;
    #1;
    checks++;
    if ({o_drive2, o_drive1, o_drive0, o_free, o_busy, o_err, o_data2, o_data1, o_data0} !== 13'd0) begin
      failures++;
      $display("FAIL midop_reset got=%b%b%b%b%b%b_%b_%b_%b exp=0", o_drive2, o_drive1, o_drive0,
               o_free, o_busy, o_err, o_data2, o_data1, o_data0);
    end
    exp_data = 7'd0;
    exp_err  = 1'b0;
    err_at   = NEVER;
    i_free0  = 1'b0;
    i_free1  = 1'b0;
    for (int k = 0; k < 3; k++) step();
    rstn = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      checks++;
      if ({o_drive0, o_busy, o_err} !== 3'b000) begin
        failures++;
        $display("FAIL held_drive k=%0d drive/busy/err got=%b%b%b exp=000", k, o_drive0, o_busy, o_err);
      end
    end
    i_drive = 1'b0;
    step();
    run_txn("after_reset", 7'($urandom), 2, 5, 3, 0, 0);
    step();
  endtask

  task automatic test_dup_free();
    run_txn("dup_free", 7'b110_010_1, 2, 14, 14, 0, 6);
    step();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    err_at   = NEVER;
    exp_err  = 1'b0;
    exp_data = 7'd0;
    rstn     = 1'b0;
    i_drive  = 1'b0;
    i_data   = 7'd0;
    i_free0  = 1'b0;
    i_free1  = 1'b0;
    i_free2  = 1'b0;
    test_reset();
    test_basic();
    test_same_cycle_free();
    test_early_free();
    test_back_to_back();
    test_drive_violation();
    test_reset_midop();
    test_dup_free();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
